// File: rtl/handshake_burst_master.sv
// Valid/ready burst source: on start it latches a configuration and sends
// bursts of generated beats (incr, decr, constant or LFSR data). It can
// auto-repeat bursts with a programmable idle gap until abort.
module handshake_burst_master #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       LEN_W    = 4,
   parameter int unsigned       GAP_W    = 4,
   parameter logic [DATA_W-1:0] LFSR_TAP = 8'hB8
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_seed,
   input  logic [GAP_W-1:0]  cfg_gap,
   input  logic              cfg_repeat,
   input  logic              abort,
   input  logic              ready_up,
   output logic              valid_up,
   output logic [DATA_W-1:0] data_up,
   output logic              last_up,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  beat_cnt
);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   localparam logic [1:0]        ModeIncr = 2'b00;
   localparam logic [1:0]        ModeDecr = 2'b01;
   localparam logic [1:0]        ModeLfsr = 2'b11;
   localparam logic [DATA_W-1:0] DataOne  = DATA_W'(1);
   localparam logic [LEN_W-1:0]  LenOne   = LEN_W'(1);
   localparam logic [GAP_W-1:0]  GapOne   = GAP_W'(1);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [1:0]          mode_q, mode_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic                repeat_q, repeat_d;
   logic                abort_seen_q, abort_seen_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                last_q, last_d;
   logic                done_q, done_d;

   logic                accept;
   logic [DATA_W-1:0]   seed_eff;
   logic [DATA_W-1:0]   data_next;

   // Output decode straight from registered state; no path from ready_up.
   assign valid_up = (state_q == StSend);
   assign busy     = (state_q != StIdle);
   assign data_up  = data_q;
   assign last_up  = last_q;
   assign done     = done_q;
   assign beat_cnt = cnt_q;
   assign accept   = valid_up & ready_up;

   // Seed as it will be stored; an all-zero LFSR would lock up, so use 1.
   always_comb begin
      seed_eff = cfg_seed;
      if (cfg_mode == ModeLfsr && cfg_seed == '0) begin
         seed_eff = DataOne;
      end
   end

   // Data value following the current beat for the latched mode.
   always_comb begin
      data_next = data_q;
      unique case (mode_q)
         ModeIncr: data_next = data_q + DataOne;
         ModeDecr: data_next = data_q - DataOne;
         ModeLfsr: data_next = {data_q[DATA_W-2:0], ^(data_q & LFSR_TAP)};
         default:  data_next = data_q;
      endcase
   end

   // Next-state and registered-output logic for the IDLE/SEND/GAP sequencer.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      mode_d       = mode_q;
      seed_d       = seed_q;
      gap_d        = gap_q;
      repeat_d     = repeat_q;
      abort_seen_d = abort_seen_q;
      gap_cnt_d    = gap_cnt_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      done_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d      = StSend;
               len_d        = cfg_len;
               mode_d       = cfg_mode;
               seed_d       = seed_eff;
               gap_d        = cfg_gap;
               repeat_d     = cfg_repeat;
               abort_seen_d = 1'b0;
               data_d       = seed_eff;
               cnt_d        = '0;
               last_d       = (cfg_len == '0);
            end
         end
         StSend: begin
            // abort only takes effect at the burst boundary
            abort_seen_d = abort_seen_q | abort;
            if (accept) begin
               if (last_q) begin
                  done_d       = 1'b1;
                  cnt_d        = '0;
                  abort_seen_d = 1'b0;
                  if (!repeat_q || abort_seen_q || abort) begin
                     state_d = StIdle;
                     data_d  = '0;
                     last_d  = 1'b0;
                  end else if (gap_q == '0) begin
                     data_d = seed_q;
                     last_d = (len_q == '0);
                  end else begin
                     state_d   = StGap;
                     gap_cnt_d = gap_q;
                     data_d    = '0;
                     last_d    = 1'b0;
                  end
               end else begin
                  cnt_d  = cnt_q + LenOne;
                  data_d = data_next;
                  last_d = ((cnt_q + LenOne) == len_q);
               end
            end
         end
         StGap: begin
            if (abort) begin
               state_d   = StIdle;
               gap_cnt_d = '0;
            end else if (gap_cnt_q == GapOne) begin
               state_d   = StSend;
               gap_cnt_d = '0;
               data_d    = seed_q;
               cnt_d     = '0;
               last_d    = (len_q == '0);
            end else begin
               gap_cnt_d = gap_cnt_q - GapOne;
            end
         end
         default: begin
            state_d = StIdle;
            data_d  = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
         end
      endcase
   end

   // State and configuration registers with asynchronous active-low reset.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         len_q        <= '0;
         mode_q       <= '0;
         seed_q       <= '0;
         gap_q        <= '0;
         repeat_q     <= 1'b0;
         abort_seen_q <= 1'b0;
         gap_cnt_q    <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         mode_q       <= mode_d;
         seed_q       <= seed_d;
         gap_q        <= gap_d;
         repeat_q     <= repeat_d;
         abort_seen_q <= abort_seen_d;
         gap_cnt_q    <= gap_cnt_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_handshake_burst_master.sv
// Directed bench for handshake_burst_master. Expected outputs are packed as
// 16'h{valid,last,busy,done}{beat_cnt}{data}, one entry per cycle after start.
module tb_handshake_burst_master;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] cfg_len;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_seed;
   logic [3:0] cfg_gap;
   logic       cfg_repeat;
   logic       abort;
   logic       ready_up;
   logic       valid_up;
   logic [7:0] data_up;
   logic       last_up;
   logic       busy;
   logic       done;
   logic [3:0] beat_cnt;

   int total = 0;
   int bad   = 0;

   handshake_burst_master #(
      .DATA_W   (8),
      .LEN_W    (4),
      .GAP_W    (4),
      .LFSR_TAP (8'hB8)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_len    (cfg_len),
      .cfg_mode   (cfg_mode),
      .cfg_seed   (cfg_seed),
      .cfg_gap    (cfg_gap),
      .cfg_repeat (cfg_repeat),
      .abort      (abort),
      .ready_up   (ready_up),
      .valid_up   (valid_up),
      .data_up    (data_up),
      .last_up    (last_up),
      .busy       (busy),
      .done       (done),
      .beat_cnt   (beat_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [15:0] obs();
      return {valid_up, last_up, busy, done, beat_cnt, data_up};
   endfunction

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // Drive a start in the current cycle; returns in cycle 1 of the burst.
   task automatic begin_burst(input logic [3:0] len, input logic [1:0] mode,
                              input logic [7:0] seed, input logic [3:0] gap,
                              input logic rep);
      cfg_len    = len;
      cfg_mode   = mode;
      cfg_seed   = seed;
      cfg_gap    = gap;
      cfg_repeat = rep;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++;
      if (obs() !== 16'h0000) begin
         bad++;
         $display("FAIL reset got=%h exp=0000", obs());
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (obs() !== 16'h0000) begin
         bad++;
         $display("FAIL reset_idle got=%h exp=0000", obs());
      end
   endtask

   task automatic test_incr();
      logic [15:0] e [5];
      e = '{16'hA005, 16'hA106, 16'hE207, 16'h1000, 16'h0000};
      begin_burst(4'd2, 2'b00, 8'h05, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (obs() !== e[i]) begin
            bad++;
            $display("FAIL incr c%0d got=%h exp=%h", i + 1, obs(), e[i]);
         end
         step();
      end
   endtask

   task automatic test_stall();
      logic [15:0] e [7];
      e = '{16'hA005, 16'hA106, 16'hA106, 16'hA106, 16'hA106, 16'hE207, 16'h1000};
      begin_burst(4'd2, 2'b00, 8'h05, 4'd0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         total++;
         if (obs() !== e[i]) begin
            bad++;
            $display("FAIL stall c%0d got=%h exp=%h", i + 1, obs(), e[i]);
         end
         ready_up = !((i + 1) >= 2 && (i + 1) <= 4);
         step();
      end
      ready_up = 1'b1;
      step();
   endtask

   task automatic test_modes();
      logic [15:0] e_dec [5];
      logic [15:0] e_lfsr [5];
      logic [15:0] e_con [4];
      logic [15:0] e_one [2];
      e_dec  = '{16'hA001, 16'hA100, 16'hA2FF, 16'hE3FE, 16'h1000};
      e_lfsr = '{16'hA001, 16'hA102, 16'hA204, 16'hE308, 16'h1000};
      e_con  = '{16'hA0AA, 16'hA1AA, 16'hE2AA, 16'h1000};
      e_one  = '{16'hE042, 16'h1000};
      begin_burst(4'd3, 2'b01, 8'h01, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (obs() !== e_dec[i]) begin
            bad++;
            $display("FAIL decr c%0d got=%h exp=%h", i + 1, obs(), e_dec[i]);
         end
         step();
      end
      begin_burst(4'd3, 2'b11, 8'h00, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (obs() !== e_lfsr[i]) begin
            bad++;
            $display("FAIL lfsr c%0d got=%h exp=%h", i + 1, obs(), e_lfsr[i]);
         end
         step();
      end
      begin_burst(4'd2, 2'b10, 8'hAA, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (obs() !== e_con[i]) begin
            bad++;
            $display("FAIL const c%0d got=%h exp=%h", i + 1, obs(), e_con[i]);
         end
         step();
      end
      begin_burst(4'd0, 2'b00, 8'h42, 4'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (obs() !== e_one[i]) begin
            bad++;
            $display("FAIL single c%0d got=%h exp=%h", i + 1, obs(), e_one[i]);
         end
         step();
      end
   endtask

   task automatic test_repeat_gap();
      logic [15:0] e [12];
      e = '{16'hA003, 16'hE104, 16'h3000, 16'h2000, 16'hA003, 16'hE104,
            16'h3000, 16'h2000, 16'hA003, 16'hE104, 16'h1000, 16'h0000};
      begin_burst(4'd1, 2'b00, 8'h03, 4'd2, 1'b1);
      for (int i = 0; i < 12; i++) begin
         total++;
         if (obs() !== e[i]) begin
            bad++;
            $display("FAIL rep_gap c%0d got=%h exp=%h", i + 1, obs(), e[i]);
         end
         abort = ((i + 1) >= 9 && (i + 1) <= 10);
         step();
      end
      abort = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] e_rep [8];
      logic [15:0] e_b2b [5];
      e_rep = '{16'hA003, 16'hE104, 16'hB003, 16'hE104, 16'hB003, 16'hE104,
                16'h1000, 16'h0000};
      e_b2b = '{16'hE001, 16'h1000, 16'hE002, 16'h1000, 16'h0000};
      begin_burst(4'd1, 2'b00, 8'h03, 4'd0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs() !== e_rep[i]) begin
            bad++;
            $display("FAIL rep_nogap c%0d got=%h exp=%h", i + 1, obs(), e_rep[i]);
         end
         abort = ((i + 1) >= 5 && (i + 1) <= 6);
         step();
      end
      abort = 1'b0;
      // A new start is accepted in the done cycle.
      begin_burst(4'd0, 2'b00, 8'h01, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (obs() !== e_b2b[i]) begin
            bad++;
            $display("FAIL b2b c%0d got=%h exp=%h", i + 1, obs(), e_b2b[i]);
         end
         if (i == 1) begin
            cfg_seed = 8'h02;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_abort_gap();
      logic [15:0] e [5];
      e = '{16'hE009, 16'h3000, 16'h2000, 16'h0000, 16'h0000};
      begin_burst(4'd0, 2'b00, 8'h09, 4'd3, 1'b1);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (obs() !== e[i]) begin
            bad++;
            $display("FAIL abort_gap c%0d got=%h exp=%h", i + 1, obs(), e[i]);
         end
         abort = ((i + 1) == 3);
         step();
      end
      abort = 1'b0;
   endtask

   task automatic test_start_ignored();
      logic [15:0] e [5];
      e = '{16'hA005, 16'hA106, 16'hE207, 16'h1000, 16'h0000};
      begin_burst(4'd2, 2'b00, 8'h05, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (obs() !== e[i]) begin
            bad++;
            $display("FAIL busy_start c%0d got=%h exp=%h", i + 1, obs(), e[i]);
         end
         if ((i + 1) == 2) begin
            start    = 1'b1;
            cfg_seed = 8'h77;
            cfg_len  = 4'd0;
            cfg_mode = 2'b01;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] e [3];
      e = '{16'hA020, 16'hE121, 16'h1000};
      begin_burst(4'd5, 2'b00, 8'h10, 4'd0, 1'b0);
      total++;
      if (obs() !== 16'hA010) begin
         bad++;
         $display("FAIL pre_reset got=%h exp=A010", obs());
      end
      step();
      rst_n = 1'b0;
      #1;
      total++;
      if (obs() !== 16'h0000) begin
         bad++;
         $display("FAIL async_reset got=%h exp=0000", obs());
      end
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (obs() !== 16'h0000) begin
         bad++;
         $display("FAIL post_reset got=%h exp=0000", obs());
      end
      begin_burst(4'd1, 2'b00, 8'h20, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs() !== e[i]) begin
            bad++;
            $display("FAIL clean_burst c%0d got=%h exp=%h", i + 1, obs(), e[i]);
         end
         step();
      end
   endtask

   initial begin
      start      = 1'b0;
      cfg_len    = '0;
      cfg_mode   = '0;
      cfg_seed   = '0;
      cfg_gap    = '0;
      cfg_repeat = 1'b0;
      abort      = 1'b0;
      ready_up   = 1'b1;
      test_reset();
      test_incr();
      test_stall();
      test_modes();
      test_repeat_gap();
      test_back_to_back();
      test_abort_gap();
      test_start_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
